// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: async-SRAM controller with an N-port arbiter.
// Serialises masters onto one 32-bit async SRAM, generating CE/OE/WE timing
// with programmable read wait states and write-pulse width.
// Optional build macro: SRAM_FIXED_PRIO_EN (fixed priority, lowest index wins);
// when undefined the arbiter is round-robin.
module sram_arb_ctrl #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int WR_PULSE    = 1
) (
  input  logic                        clk_50M,
  input  logic                        reset_btn,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0] be,
  output logic [NUM_PORTS-1:0]        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  inout  wire  [DATA_W-1:0]           ram_data,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W/8-1:0]         ram_be_n,
  output logic                        ram_ce_n,
  output logic                        ram_oe_n,
  output logic                        ram_we_n
);

  localparam int BE_W    = DATA_W / 8;
  localparam int PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int MAX_CNT = (WAIT_CYCLES > WR_PULSE) ? WAIT_CYCLES : WR_PULSE;
  localparam int CNT_W   = $clog2(MAX_CNT + 1) + 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  // RT: one-cycle read turnaround with all strobes released, so the SRAM
  // has let go of the data bus before a following write may drive it.
  localparam logic [2:0] ST_RT   = 3'd2;
  localparam logic [2:0] ST_WS   = 3'd3;
  localparam logic [2:0] ST_WP   = 3'd4;
  localparam logic [2:0] ST_WH   = 3'd5;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [PTR_W-1:0]  win_q;
  logic [PTR_W-1:0]  win_sel;
  logic              grant_any;
  logic              grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              drive;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PTR_W-1:0] p);
    logic [NUM_PORTS-1:0] r;
    for (int i = 0; i < NUM_PORTS; i++) r[i] = (p == PTR_W'(i));
    return r;
  endfunction

`ifdef SRAM_FIXED_PRIO_EN
  // Fixed-priority pick: the lowest-numbered requesting port wins.
  always_comb begin
    win_sel   = '0;
    grant_any = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req[k]) begin
        win_sel   = PTR_W'(k);
        grant_any = 1'b1;
      end
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_cand;

  // Round-robin pick: search starts at rr_ptr, the port after the last winner.
  always_comb begin
    win_sel   = '0;
    grant_any = 1'b0;
    rr_cand   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      rr_cand = PTR_W'((int'(rr_ptr) + k) % NUM_PORTS);
      if (!grant_any && req[rr_cand]) begin
        win_sel   = rr_cand;
        grant_any = 1'b1;
      end
    end
  end

  // Pointer advances past the winner only when a grant is actually made.
  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (win_sel == PTR_W'(NUM_PORTS - 1)) ? '0 : win_sel + 1'b1;
    end
  end
`endif

  // No new grant while an ack is on the wire, so the master can react to it.
  assign grant = (state == ST_IDLE) && grant_any && (ack == '0);

  // Transaction FSM: latch the winner, sequence strobes, capture read data, ack.
  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      ack    <= '0;
      rdata  <= '0;
      addr_q <= '0;
      be_q   <= '0;
      win_q  <= '0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            win_q  <= win_sel;
            addr_q <= addr[win_sel*ADDR_W +: ADDR_W];
            be_q   <= be[win_sel*BE_W +: BE_W];
            cnt    <= '0;
            state  <= we[win_sel] ? ST_WS : ST_RD;
          end
        end
        ST_RD: begin
          if (cnt == CNT_W'(WAIT_CYCLES)) begin
            rdata <= ram_data;
            state <= ST_RT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RT: begin
          ack   <= port_onehot(win_q);
          state <= ST_IDLE;
        end
        ST_WS: begin
          cnt   <= '0;
          state <= ST_WP;
        end
        ST_WP: begin
          if (cnt == CNT_W'(WR_PULSE - 1)) state <= ST_WH;
          else                             cnt   <= cnt + 1'b1;
        end
        ST_WH: begin
          ack   <= port_onehot(win_q);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write data is pure datapath; it is only visible on the bus in WS/WP/WH.
  always_ff @(posedge clk_50M) begin
    if (state == ST_IDLE && grant) wdata_q <= wdata[win_sel*DATA_W +: DATA_W];
  end

  // Strobe decode from the registered state; OE and WE are never low together.
  always_comb begin
    ram_ce_n = 1'b1;
    ram_oe_n = 1'b1;
    ram_we_n = 1'b1;
    ram_be_n = '1;
    drive    = 1'b0;
    case (state)
      ST_RD: begin
        ram_ce_n = 1'b0;
        ram_oe_n = 1'b0;
        ram_be_n = ~be_q;
      end
      ST_WS, ST_WH: begin
        ram_ce_n = 1'b0;
        ram_be_n = ~be_q;
        drive    = 1'b1;
      end
      ST_WP: begin
        ram_ce_n = 1'b0;
        ram_we_n = 1'b0;
        ram_be_n = ~be_q;
        drive    = 1'b1;
      end
      default: ;
    endcase
  end

  assign ram_addr = addr_q;
  assign ram_data = drive ? wdata_q : {DATA_W{1'bz}};
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// tb_sram_arb_ctrl: directed bench for sram_arb_ctrl with a behavioural SRAM
// on the bus and a bus-safety monitor.
module tb_sram_arb_ctrl;

  logic        clk = 1'b0;
  logic        reset_btn = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [39:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [7:0]  be = '0;
  wire  [1:0]  ack;
  wire  [31:0] rdata;
  wire         busy;
  wire  [31:0] ram_data;
  wire  [19:0] ram_addr;
  wire  [3:0]  ram_be_n;
  wire         ram_ce_n;
  wire         ram_oe_n;
  wire         ram_we_n;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  logic        probe_en = 1'b0;
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:15];

  int          t_lat;
  logic [31:0] t_rd;
  logic [7:0]  t_wen;
  logic [7:0]  t_oen;
  logic [3:0]  t_benwp;

  int          nack;
  int          ack_cyc [4];
  logic [7:0]  order;
  logic        saw_ack;
  logic [7:0]  exp_order;

  sram_arb_ctrl dut (
    .clk_50M  (clk),
    .reset_btn(reset_btn),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .be       (be),
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy),
    .ram_data (ram_data),
    .ram_addr (ram_addr),
    .ram_be_n (ram_be_n),
    .ram_ce_n (ram_ce_n),
    .ram_oe_n (ram_oe_n),
    .ram_we_n (ram_we_n)
  );

  always #10 clk = ~clk;

  // Behavioural SRAM: drives on CE&OE, writes enabled bytes while CE&WE low.
  assign ram_data = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[7:0]] :
                    (probe_en ? 32'h0 : 32'hzzzz_zzzz);

  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!ram_be_n[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_data[b*8 +: 8];
    end
  end

  // Bus-safety monitor.
  always @(negedge clk) begin
    if (!ram_oe_n && !ram_we_n) viol <= viol + 1;
    else if ($countones(ack) > 1) viol <= viol + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one transaction on port p starting in the current cycle (cycle 0).
  task automatic do_txn(input int p, input logic w, input logic [19:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    req[p] = 1'b1;
    we[p]  = w;
    addr[p*20 +: 20]  = a;
    wdata[p*32 +: 32] = d;
    be[p*4 +: 4]      = b;
    t_lat = -1; t_rd = '0; t_wen = '1; t_oen = '1; t_benwp = '1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c < 8) begin
        t_wen[c] = ram_we_n;
        t_oen[c] = ram_oe_n;
      end
      if (!ram_we_n) t_benwp = ram_be_n;
      if (ack[p]) begin
        t_lat = c;
        t_rd  = rdata;
        break;
      end
    end
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack",   ack, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    check("rst_busy",  busy, 1'b0);
    check("rst_addr",  ram_addr, 20'h0);
    check("rst_strb",  {ram_ce_n, ram_oe_n, ram_we_n, ram_be_n}, 7'h7F);
    @(posedge clk); #1;
    reset_btn = 1'b0;

    // 1: full write
    do_txn(0, 1'b1, 20'h00010, 32'hDEADBEEF, 4'hF);
    check("t1_lat",  t_lat, 4);
    check("t1_wen",  t_wen[4:0], 5'b11011);
    check("t1_oen",  t_oen[4:0], 5'b11111);
    check("t1_ben",  t_benwp, 4'b0000);

    // 2: read-back
    do_txn(0, 1'b0, 20'h00010, 32'h0, 4'hF);
    check("t2_lat",   t_lat, 4);
    check("t2_oen",   t_oen[4:0], 5'b11001);
    check("t2_wen",   t_wen[4:0], 5'b11111);
    check("t2_rdata", t_rd, 32'hDEADBEEF);

    // 3: byte write then read
    do_txn(0, 1'b1, 20'h00010, 32'h0000AA00, 4'b0010);
    check("t3_ben",   t_benwp, 4'b1101);
    do_txn(0, 1'b0, 20'h00010, 32'h0, 4'hF);
    check("t3_rdata", t_rd, 32'hDEADAAEF);

    // be==0 write: full cycle, ack, nothing written
    do_txn(0, 1'b1, 20'h00010, 32'h11111111, 4'b0000);
    check("be0_lat", t_lat, 4);
    check("be0_ben", t_benwp, 4'b1111);
    do_txn(0, 1'b0, 20'h00010, 32'h0, 4'hF);
    check("be0_rdata", t_rd, 32'hDEADAAEF);

    // 5: reset asserted during the write pulse (port 1)
    req[1] = 1'b1; we[1] = 1'b1; addr[39:20] = 20'h00030;
    wdata[63:32] = 32'h12345678; be[7:4] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_in_wp", ram_we_n, 1'b0);
    reset_btn = 1'b1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    reset_btn = 1'b0;
    check("t5_strb",  {ram_ce_n, ram_oe_n, ram_we_n, ram_be_n}, 7'h7F);
    check("t5_busy",  busy, 1'b0);
    check("t5_addr",  ram_addr, 20'h0);
    check("t5_rdata", rdata, 32'h0);
    probe_en = 1'b1;
    #1;
    check("t5_bus_float", ram_data, 32'h0);
    probe_en = 1'b0;
    saw_ack = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack != 2'b00) saw_ack = 1'b1;
    end
    check("t5_no_ack", saw_ack, 1'b0);
    @(posedge clk); #1;
    do_txn(1, 1'b0, 20'h00030, 32'h0, 4'hF);
    check("t5_lat",   t_lat, 4);
    check("t5_mem",   t_rd, 32'h12345678);

    // 4: contention, both ports hold req across four transactions
    req = 2'b11; we = 2'b00;
    addr = {20'h00020, 20'h00010};
    be = 8'hFF;
    nack = 0; order = '0;
    for (int c = 0; c < 60 && nack < 4; c++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        ack_cyc[nack] = c;
        order[nack*2 +: 2] = ack[1] ? 2'd1 : 2'd0;
        check("t4_rdata", rdata, ack[1] ? 32'h0 : 32'hDEADAAEF);
        nack++;
      end
    end
    @(posedge clk); #1;
    req = 2'b00;
    check("t4_count", nack, 4);
`ifdef SRAM_FIXED_PRIO_EN
    exp_order = 8'h00;
`else
    exp_order = 8'h44;
`endif
    check("t4_order", order, exp_order);
    check("t4_gap",   ack_cyc[1] - ack_cyc[0], 5);
    check("t4_span",  ack_cyc[3] - ack_cyc[0], 15);

    // 6: random single-stream traffic against a reference memory
    for (int n = 0; n < 400; n++) begin
      int          p;
      logic        w;
      logic [3:0]  idx;
      logic [3:0]  b;
      logic [31:0] d;
      p   = int'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      idx = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      d   = $urandom;
      do_txn(p, w, {12'h000, 4'h8, idx}, d, b);
      check("rnd_lat", t_lat, 4);
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) ref_mem[idx][k*8 +: 8] = d[k*8 +: 8];
      end else begin
        check("rnd_rdata", t_rd, ref_mem[idx]);
      end
    end

    check("bus_safety", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
